coefficient_loader: RTL and testbench

Sequencer that sits directly upstream of `coefficient_file` and drives its `wr_en`/`wr_data` port. On a `start` pulse it accepts a kernel of size k×k (k odd, 1..MASK_WIDTH) from a valid/ready stream. It centres that kernel inside the MASK_WIDTH×MASK_WIDTH mask by inserting zero padding. It then emits exactly MASK_WIDTH² writes, so the shift-register file always ends up fully and deterministically loaded.

---
 rtl/coefficient_pkg.sv | 14 +
 rtl/coefficient_pos_counter.sv | 44 ++++
 rtl/coefficient_loader.sv | 72 +++++++
 tb/tb_coefficient_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/coefficient_pkg.sv
// coefficient_pkg: shared types, default geometry and k_size legality check
package coefficient_pkg;
    localparam int COFCNT_BIT_DEF = 16;
    localparam int MASK_WIDTH_DEF = 7;
    localparam int MASK_WORDS     = MASK_WIDTH_DEF * MASK_WIDTH_DEF;
    localparam int IDX_W          = $clog2(MASK_WORDS);
    localparam int KS_W           = $clog2(MASK_WIDTH_DEF + 1);

    typedef enum logic {IDLE, LOAD} state_t;

    function automatic logic k_legal(input int k, input int mw);
        return (k >= 1) && (k <= mw) && (k % 2 == 1);
    endfunction
endpackage

// File: rtl/coefficient_pos_counter.sv
// coefficient_pos_counter: row/col scan over the mask with last-position flag
// and a window compare against the centred kernel bounds latched at load.
module coefficient_pos_counter
    import coefficient_pkg::*;
#(
    parameter int MASK_WIDTH = MASK_WIDTH_DEF,
    parameter int KW         = $clog2(MASK_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [KW-1:0] i_k,
    input  logic          i_adv,
    output logic          o_inside,
    output logic          o_last
);
    localparam int RC_W = $clog2(MASK_WIDTH);
    localparam logic [RC_W-1:0] LAST = RC_W'(MASK_WIDTH - 1);

    logic [RC_W-1:0] r_row, r_col, r_lo, r_hi;
    logic [RC_W-1:0] w_lo;

    assign w_lo = RC_W'((MASK_WIDTH - int'(i_k)) / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
        end else if (i_load) begin
            r_row <= '0;
            r_col <= '0;
            r_lo  <= w_lo;
            r_hi  <= w_lo + RC_W'(i_k) - RC_W'(1);
        end else if (i_adv) begin
            r_col <= (r_col == LAST) ? '0 : r_col + RC_W'(1);
            r_row <= (r_col != LAST) ? r_row : (r_row == LAST) ? '0 : r_row + RC_W'(1);
        end
    end

    assign o_last   = (r_row == LAST) && (r_col == LAST);
    assign o_inside = (r_row >= r_lo) && (r_row <= r_hi) && (r_col >= r_lo) && (r_col <= r_hi);
endmodule

// File: rtl/coefficient_loader.sv
// coefficient_loader: accepts a k x k kernel from a valid/ready stream and emits
// exactly MASK_WIDTH^2 writes with the kernel centred in zero padding.
module coefficient_loader
    import coefficient_pkg::*;
#(
    parameter int COFCNT_BIT = COFCNT_BIT_DEF,
    parameter int MASK_WIDTH = MASK_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(MASK_WIDTH+1)-1:0] k_size,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [COFCNT_BIT-1:0]           s_data,
    output logic                            wr_en,
    output logic [COFCNT_BIT-1:0]           wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    state_t r_state, w_next;
    logic   r_wr_en, r_done, r_err;
    logic [COFCNT_BIT-1:0] r_wr_data;
    logic   w_inside, w_last, w_idle, w_accept, w_adv;

    coefficient_pos_counter #(.MASK_WIDTH(MASK_WIDTH)) u_pos (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_accept),
        .i_k     (k_size),
        .i_adv   (w_adv),
        .o_inside(w_inside),
        .o_last  (w_last)
    );

    // The done cycle still counts as busy, so a start there is rejected.
    assign w_idle   = (r_state == IDLE) && !r_done;
    assign w_accept = start && w_idle && k_legal(int'(k_size), MASK_WIDTH);
    assign w_adv    = (r_state == LOAD) && (!w_inside || s_valid);

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept)
            w_next = LOAD;
        else if (r_state == LOAD && w_adv && w_last)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_en   <= w_adv;
            r_wr_data <= (w_adv && w_inside) ? s_data : '0;
            r_done    <= w_adv && w_last;
            r_err     <= start && !w_accept;
        end
    end

    assign s_ready = (r_state == LOAD) && w_inside;
    assign busy    = (r_state == LOAD) || r_done;
    assign wr_en   = r_wr_en;
    assign wr_data = r_wr_data;
    assign done    = r_done;
    assign err     = r_err;
endmodule

// File: tb/tb_coefficient_loader.sv
// tb_coefficient_loader: table-driven start checks plus directed and random
// loads compared against a padded-kernel reference model.
module tb_coefficient_loader;
    localparam int MW = 7;
    localparam int CB = 16;
    localparam int NW = MW * MW;

    logic          clk = 0, reset = 0, start = 0, s_valid = 0;
    logic [2:0]    k_size = 0;
    logic [CB-1:0] s_data = 0;
    logic          s_ready, wr_en, busy, done, err;
    logic [CB-1:0] wr_data;

    always #5 clk = ~clk;

    coefficient_loader #(.COFCNT_BIT(CB), .MASK_WIDTH(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_size(k_size),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    int n_cmp = 0, n_bad = 0;
    logic [CB-1:0] kern[NW];
    logic [CB-1:0] got[$];

    typedef struct {int k; int exp_err; int exp_busy;} vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic int ref_word(input int k, input int i);
        int off = (MW - k) / 2;
        int r = i / MW;
        int c = i % MW;
        if (r >= off && r < off + k && c >= off && c < off + k)
            return int'(kern[(r - off) * k + (c - off)]);
        return 0;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, " s_ready"}, s_ready, 0);
        chk({nm, " wr_en"}, wr_en, 0);
        chk({nm, " wr_data"}, wr_data, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " err"}, err, 0);
    endtask

    // mode 0: valid held high (extra words offered), 1: toggling, 2: random
    task automatic do_load(input string nm, input int k, input int mode,
                           input int inject_at, input int abort_after);
        int ptr = 0, hs = 0, nerr = 0, first = -1, done_it = -1;
        got.delete();
        @(negedge clk);
        start = 1;
        k_size = 3'(k);
        @(negedge clk);
        start = 0;
        chk({nm, " busy_after_start"}, busy, 1);
        for (int it = 0; it < 600; it++) begin
            if (wr_en) begin
                if (first < 0) first = it;
                got.push_back(wr_data);
            end
            if (err) nerr++;
            if (done) begin
                done_it = it;
                chk({nm, " done_at_write"}, got.size(), NW);
                break;
            end
            if (abort_after > 0 && got.size() == abort_after) begin
                reset = 0;
                #1;
                chk_all_zero({nm, " reset"});
                s_valid = 0;
                @(negedge clk);
                reset = 1;
                return;
            end
            start   = (it == inject_at);
            k_size  = (it == inject_at) ? 3'd3 : 3'(k);
            s_valid = (mode == 0) || (ptr < k * k &&
                      ((mode == 1 && it % 2 == 0) || (mode == 2 && $urandom_range(1, 0) == 1)));
            s_data  = (ptr < k * k) ? kern[ptr] : 16'hDEAD;
            if (s_ready && s_valid) begin
                hs++;
                ptr++;
            end
            @(negedge clk);
        end
        start = 0;
        s_valid = 0;
        chk({nm, " finished"}, done_it >= 0, 1);
        chk({nm, " write_count"}, got.size(), NW);
        for (int i = 0; i < NW && i < got.size(); i++)
            chk($sformatf("%s word%0d", nm, i), got[i], ref_word(k, i));
        chk({nm, " handshakes"}, hs, k * k);
        chk({nm, " err_pulses"}, nerr, (inject_at >= 0) ? 1 : 0);
        if (mode == 0) chk({nm, " cycles"}, done_it - first + 1, NW);
        @(negedge clk);
        chk({nm, " busy_after_done"}, busy, 0);
    endtask

    initial begin
        #1;
        chk_all_zero("por");
        repeat (2) @(negedge clk);
        reset = 1;

        for (int k = 0; k < 8; k++) vecs[k] = '{k, (k % 2 == 0) ? 1 : 0, (k % 2 == 1) ? 1 : 0};
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            start = 1;
            k_size = 3'(vecs[v].k);
            @(negedge clk);
            start = 0;
            chk($sformatf("start_k%0d err", vecs[v].k), err, vecs[v].exp_err);
            chk($sformatf("start_k%0d busy", vecs[v].k), busy, vecs[v].exp_busy);
            if (vecs[v].exp_busy != 0) begin
                reset = 0;
                #1;
                chk($sformatf("start_k%0d reset_busy", vecs[v].k), busy, 0);
                @(negedge clk);
                reset = 1;
            end
        end

        for (int i = 0; i < NW; i++) kern[i] = CB'(i + 1);
        do_load("k7", 7, 0, -1, 0);
        chk("k7 low_word", got.size() > 0 ? got[0] : 0, 1);
        chk("k7 top_word", got.size() == NW ? got[NW-1] : 0, 49);

        for (int i = 0; i < NW; i++) kern[i] = CB'(16'hA0 + i);
        do_load("k3", 3, 0, -1, 0);
        chk("k3 idx16", got.size() == NW ? got[16] : 0, 16'hA0);
        chk("k3 idx32", got.size() == NW ? got[32] : 0, 16'hA8);

        for (int i = 0; i < NW; i++) kern[i] = CB'($urandom);
        do_load("k5_toggle", 5, 1, -1, 0);

        kern[0] = 16'h1234;
        do_load("k1", 1, 0, -1, 0);
        chk("k1 idx24", got.size() == NW ? got[24] : 0, 16'h1234);

        foreach (vecs[v]) if (vecs[v].k == 4 || vecs[v].k == 0) begin
            @(negedge clk);
            start = 1;
            k_size = 3'(vecs[v].k);
            @(negedge clk);
            start = 0;
            chk($sformatf("illegal_k%0d err", vecs[v].k), err, 1);
            chk($sformatf("illegal_k%0d busy", vecs[v].k), busy, 0);
        end
        for (int i = 0; i < NW; i++) kern[i] = CB'($urandom);
        do_load("k5_inject", 5, 2, 10, 0);

        for (int i = 0; i < NW; i++) kern[i] = CB'(i + 1);
        do_load("abort", 7, 0, -1, 20);
        do_load("after_abort", 7, 0, -1, 0);

        repeat (6) begin
            int k = 2 * int'($urandom_range(3, 0)) + 1;
            for (int i = 0; i < NW; i++) kern[i] = CB'($urandom);
            do_load($sformatf("rand_k%0d", k), k, 2, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
